// File: rtl/seq_pkg.sv
// Shared elaboration-time helpers for serial pattern detectors: prefix/suffix
// border length and the failure-function next-state computation.
package seq_pkg;

    localparam int unsigned MAX_LEN = 16;

    // Bit idx of a pattern vector, with idx of any width.
    function automatic logic pbit(input logic [MAX_LEN-1:0] pattern, input int unsigned idx);
        logic [MAX_LEN-1:0] t;
        t = pattern >> idx;
        return t[0];
    endfunction

    // Length of the longest proper prefix of the pattern that is also its suffix.
    function automatic int unsigned border_len(input logic [MAX_LEN-1:0] pattern,
                                               input int unsigned        len);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int unsigned m = 0; m < j; m++) begin
                if (pbit(pattern, len - 1 - m) != pbit(pattern, j - 1 - m)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    // Matched-prefix length after consuming bit b from state k.
    function automatic int unsigned next_state(input logic [MAX_LEN-1:0] pattern,
                                               input int unsigned        len,
                                               input int unsigned        k,
                                               input logic               b,
                                               input logic               overlap);
        int unsigned res;
        int unsigned idx;
        logic        ok;
        logic        sbit;
        res = 0;
        if (k == len - 1 && b == pbit(pattern, 0)) begin
            res = overlap ? border_len(pattern, len) : 0;
        end else begin
            // Received string is the first k pattern bits followed by b.
            for (int unsigned j = 1; j <= k + 1; j++) begin
                ok = 1'b1;
                for (int unsigned m = 0; m < j; m++) begin
                    idx  = k + 1 - j + m;
                    sbit = (idx == k) ? b : pbit(pattern, len - 1 - idx);
                    if (sbit != pbit(pattern, len - 1 - m)) ok = 1'b0;
                end
                if (ok && j < len) res = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat_q) begin
            cnt_d = cnt_q + W'(1);
        end
        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: Mealy match, registered match and a
// saturating match counter. Transitions come from a table built at elaboration.
module seq_detect_param #(
    parameter int unsigned     LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1010,
    parameter bit              OVERLAP = 1'b1,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             i,
    input  logic             clr_cnt,
    output logic             y,
    output logic             y_reg,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    import seq_pkg::*;

    localparam int unsigned KW = (LEN > 1) ? $clog2(LEN) : 1;

    if (LEN < 2 || LEN > MAX_LEN) begin : g_bad_len
        $error("seq_detect_param: LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W must be at least 1");
    end

    // Indexed by {k, bit}; unreachable states (k >= LEN) map to 0.
    logic [KW-1:0] nxt_tab [2**(KW+1)];

    for (genvar s = 0; s < 2**KW; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int unsigned NS = (s < LEN)
                ? next_state(MAX_LEN'(PATTERN), LEN, s, 1'(b), OVERLAP) : 0;
            assign nxt_tab[2*s+b] = KW'(NS);
        end
    end

    logic [KW-1:0] k_q, k_d;
    logic          y_reg_q;
    logic          match_c;

    assign match_c = (k_q == KW'(LEN - 1)) && (i == PATTERN[0]);
    assign y       = rst && en && match_c;

    always_comb begin
        k_d = k_q;
        if (en) begin
            k_d = nxt_tab[{k_q, i}];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q     <= '0;
            y_reg_q <= 1'b0;
        end else begin
            k_q     <= k_d;
            y_reg_q <= y;
        end
    end

    assign y_reg = y_reg_q;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (y),
        .clr   (clr_cnt),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 4-bit "1010" Mealy detector.
- Detects any LEN-bit PATTERN on a 1-bit serial input.
- Overlap and non-overlap modes are selectable.
- Provides a Mealy (same-cycle) match output, a registered match output, input enable, and a saturating match counter.
- Sits directly on a serial data line in the FPGA test designs.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010, pattern to detect. PATTERN[LEN-1] is the first bit received; PATTERN[0] is the last.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = detector restarts from empty after each match.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  input-valid qualifier; the bit on i is consumed only when en=1.
- i  in  1  serial data bit.
- clr_cnt  in  1  synchronous clear of match_cnt.
- y  out  1  Mealy match; combinational from state, en and i.
- y_reg  out  1  y registered; one cycle later.
- match_cnt  out  CNT_W  number of matches since reset/clear; saturating.
- cnt_sat  out  1  high while match_cnt is all ones.

Behaviour:
- State register holds k = number of pattern prefix bits currently matched; range 0..LEN-1; width clog2(LEN).
- Reset (rst=0, async):
  - k=0, y_reg=0, match_cnt=0, so cnt_sat=0.
  - y is 0 while in reset.
- Reset deassertion: takes effect at the next clk edge. Reset mid-stream discards any partial match.
- en=0: k, y_reg input and match_cnt all hold; y=0; i is ignored.
- en=1, bit consumed:
  - Match condition: k==LEN-1 and i==PATTERN[0].
  - y = 1 in the same cycle as the match condition (zero latency, Mealy).
  - On match: next k = B if OVERLAP=1, else 0. B = length of the longest proper prefix of PATTERN that is also its suffix.
  - On non-match: next k = length of the longest pattern prefix that is a suffix of the last k received bits followed by i.
  - Non-match includes k==LEN-1 with the wrong bit; the detector falls back, it does not reset to 0.
- Next-state table is computed at elaboration (failure-function style); no runtime table.
- For PATTERN=1010, OVERLAP=1 the transitions are exactly:
  - 0: i=1→1, i=0→0
  - 1: i=1→1, i=0→2
  - 2: i=1→3, i=0→0
  - 3: i=1→1, i=0→2 (i=0 is a match)
- y_reg <= y on every clk edge (including en=0 cycles, where it captures 0).
- match_cnt, priority order:
  - clr_cnt=1 → 0, even if a match occurs that cycle (the match is dropped from the count).
  - else y=1 and not saturated → +1.
  - else hold.
- Saturated counter stays all ones until clr_cnt or reset; y still pulses normally.
- Back-to-back matches are possible only when B = LEN-1, e.g. PATTERN=1111 with OVERLAP=1. Then y may be high on consecutive cycles, and each one counts.
- Elaboration errors: LEN<2, or CNT_W<1.

Decomposition:
- Shared package seq_pkg holds:
  - the elaboration-time function next_state(pattern, len, k, bit, overlap) returning the next k;
  - the function border_len(pattern, len).
- Sub-module sat_counter (parameter W; inputs inc, clr; outputs cnt, sat) implements the counter and is reusable elsewhere.

Test Plan:
- Reset/hold: rst=0 mid-stream after bits 1,0,1 → y=0, y_reg=0, match_cnt=0. After release, stream 0 produces no match (k restarted at 0).
- Overlap, default params: stream 1,0,1,0,1,0 with en=1 → y=1 on bit 4 and bit 6; y_reg high one cycle after each; match_cnt=2.
- Non-overlap (OVERLAP=0): stream 1,0,1,0,1,0,1,0 → y=1 on bits 4 and 8 only; match_cnt=2.
- Enable gaps: bits 1,0,(en=0, i=1),1,0 → gap cycle ignored; y=1 on final bit; match_cnt=1.
- Fallback: stream 1,0,1,1,0,1,0 → no match at bit 4. State path 1,2,3,1,2,3, then match on bit 7; match_cnt=1.
- Saturation/clear (CNT_W=2, PATTERN=11, OVERLAP=1): eight consecutive 1s → y high on bits 2..8. match_cnt goes 1,2,3 then holds 3, with cnt_sat=1. clr_cnt=1 in the same cycle as a match → match_cnt=0 next cycle.
